// File: rtl/tff_link_pkg.sv
// Shared definitions for the toggle-encoded serial link (transmitter and decoder).
// Holds the deframer state encoding, the default sync byte and the parity helper.
package tff_link_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } link_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  // Widest payload the parity helper accepts; narrower bytes are zero-extended.
  localparam int PAR_MAX_W = 32;

  // Even parity: the transmitter sends this bit, so a clean byte plus bit XORs to 0.
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/tff_line_decoder_if.sv
// Line-side and byte-stream signals of the toggle-line decoder.
// master drives the line strobe/level and the consumer ready; slave is the decoder.
interface tff_line_decoder_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              line_in;
  logic [DATA_W-1:0] out_data;
  logic              out_perr;
  logic              out_valid;
  logic              out_ready;
  logic              frame_done;
  logic              overrun;
  logic              in_frame;

  modport master (
    output bit_en, line_in, out_ready,
    input  out_data, out_perr, out_valid, frame_done, overrun, in_frame
  );

  modport slave (
    input  bit_en, line_in, out_ready,
    output out_data, out_perr, out_valid, frame_done, overrun, in_frame
  );
endinterface

// File: rtl/tff_bit_decode.sv
// Toggle-line bit recovery: a toggle since the previous strobe decodes as 1.
// Combinational d for the current strobe; line_prev only advances when bit_en is high.
module tff_bit_decode (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic line_in,
  output logic d,
  output logic d_valid
);

  logic line_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev <= 1'b0;
    end else if (bit_en) begin
      line_prev <= line_in;
    end
  end

  assign d       = line_in ^ line_prev;
  assign d_valid = bit_en;

endmodule

// File: rtl/tff_line_decoder.sv
// Toggle-line receiver: sync hunt, fixed-length frame deframing, parity check; byte valid the cycle after its parity strobe.
// A byte completing while the output register is still held is dropped and flagged with an overrun pulse.
module tff_line_decoder
  import tff_link_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter logic [7:0]  SYNC        = SYNC_DEFAULT,
  parameter int          FRAME_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  tff_line_decoder_if.slave   lnk
);

  localparam int BIT_W  = (DATA_W > 1)      ? $clog2(DATA_W)      : 1;
  localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  logic d;
  logic d_valid;

  tff_bit_decode u_bit_decode (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (lnk.bit_en),
    .line_in (lnk.line_in),
    .d       (d),
    .d_valid (d_valid)
  );

  link_state_t       state;
  logic [7:0]        window;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;

  logic [DATA_W-1:0] out_data_q;
  logic              out_perr_q;
  logic              out_valid_q;
  logic              frame_done_q;
  logic              overrun_q;
  logic              in_frame_q;

  logic [7:0]        win_next;
  logic              byte_done;
  logic              last_byte;
  logic              perr;

  assign win_next  = {window[6:0], d};
  assign byte_done = d_valid && (state == PARITY);
  assign last_byte = (byte_cnt == BYTE_W'(FRAME_BYTES - 1));
  assign perr      = parity_of(PAR_MAX_W'(shreg)) ^ d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      window       <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      out_data_q   <= '0;
      out_perr_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      in_frame_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      // A completing byte may replace a byte the consumer takes in this same cycle.
      if (byte_done) begin
        if (!out_valid_q || lnk.out_ready) begin
          out_data_q  <= shreg;
          out_perr_q  <= perr;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q   <= 1'b1;
        end
        if (last_byte) begin
          frame_done_q <= 1'b1;
        end
      end else if (out_valid_q && lnk.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (d_valid) begin
        case (state)
          HUNT: begin
            window <= win_next;
            if (win_next == SYNC) begin
              state      <= DATA;
              bit_cnt    <= '0;
              byte_cnt   <= '0;
              in_frame_q <= 1'b1;
            end
          end
          DATA: begin
            shreg <= {shreg[DATA_W-2:0], d};
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state   <= PARITY;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            // Parity errors are only reported; the frame always runs its full length.
            if (last_byte) begin
              state      <= HUNT;
              window     <= '0;
              byte_cnt   <= '0;
              in_frame_q <= 1'b0;
            end else begin
              state    <= DATA;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: begin
            state      <= HUNT;
            window     <= '0;
            in_frame_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lnk.out_data   = out_data_q;
  assign lnk.out_perr   = out_perr_q;
  assign lnk.out_valid  = out_valid_q;
  assign lnk.frame_done = frame_done_q;
  assign lnk.overrun    = overrun_q;
  assign lnk.in_frame   = in_frame_q;

endmodule

// File: tb/tb_tff_line_decoder.sv
// Directed bench for tff_line_decoder: table of whole frames plus hand-written
// sequences for idle line, sync overlap and reset in the middle of a byte.
module tb_tff_line_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tff_line_decoder_if #(.DATA_W(8)) lnk ();

  tff_line_decoder #(
    .DATA_W      (8),
    .SYNC        (8'h7E),
    .FRAME_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor sampled mid-cycle: a handshake seen here completes at the next rising edge.
  logic [8:0] got_q[$];
  int         fd_cnt  = 0;
  int         ovr_cnt = 0;
  int         inf_cyc = 0;
  int         val_cyc = 0;
  logic [7:0] fd_data = 8'h00;

  always @(negedge clk) begin
    if (lnk.out_valid && lnk.out_ready) got_q.push_back({lnk.out_perr, lnk.out_data});
    if (lnk.frame_done) begin
      fd_cnt++;
      fd_data = lnk.out_data;
    end
    if (lnk.overrun)   ovr_cnt++;
    if (lnk.in_frame)  inf_cyc++;
    if (lnk.out_valid) val_cyc++;
  end

  logic line_lvl = 1'b0;
  int   gap      = 0;

  task automatic cyc(input logic en, input logic ln);
    lnk.bit_en  = en;
    lnk.line_in = ln;
    @(posedge clk);
    #1;
  endtask

  // Gap cycles drive the opposite level to prove the line is ignored without a strobe.
  task automatic send_bit(input logic b);
    line_lvl = line_lvl ^ b;
    cyc(1'b1, line_lvl);
    for (int g = 0; g < gap; g++) cyc(1'b0, ~line_lvl);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_data_byte(input logic [7:0] v, input logic flip);
    send_byte(v);
    send_bit((^v) ^ flip);
  endtask

  task automatic send_frame(input logic [3:0][7:0] fd, input logic [3:0] pf);
    send_byte(8'h7E);
    for (int k = 0; k < 4; k++) send_data_byte(fd[k], pf[k]);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, line_lvl);
  endtask

  typedef struct {
    logic [3:0][7:0] data;
    logic [3:0]      pflip;
    logic            rdy;
    int              gap;
    int              exp_n;
    logic [3:0][8:0] exp;
    int              exp_ovr;
    int              exp_fd;
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int idx,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic [3:0] pf, input logic rdy, input int gp, input int n,
                         input logic [8:0] e0, input logic [8:0] e1,
                         input logic [8:0] e2, input logic [8:0] e3,
                         input int ovr, input int fdn);
    vecs[idx].data[0] = d0; vecs[idx].data[1] = d1;
    vecs[idx].data[2] = d2; vecs[idx].data[3] = d3;
    vecs[idx].pflip   = pf;
    vecs[idx].rdy     = rdy;
    vecs[idx].gap     = gp;
    vecs[idx].exp_n   = n;
    vecs[idx].exp[0]  = e0; vecs[idx].exp[1] = e1;
    vecs[idx].exp[2]  = e2; vecs[idx].exp[3] = e3;
    vecs[idx].exp_ovr = ovr;
    vecs[idx].exp_fd  = fdn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int q0, f0, o0, i0, v0;
    logic [3:0][7:0] fr;

    // Exp entries are {perr, data}. Vector 2 holds 0xA5 while the other three are dropped.
    set_vec(0, 8'hA5, 8'h3C, 8'hFF, 8'h00, 4'b0000, 1'b1, 0, 4,
            9'h0A5, 9'h03C, 9'h0FF, 9'h000, 0, 1);
    set_vec(1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 4'b0010, 1'b1, 0, 4,
            9'h0A5, 9'h13C, 9'h0FF, 9'h000, 0, 1);
    set_vec(2, 8'hA5, 8'h3C, 8'hFF, 8'h00, 4'b0000, 1'b0, 0, 1,
            9'h0A5, 9'h000, 9'h000, 9'h000, 3, 1);
    set_vec(3, 8'hA5, 8'h3C, 8'hFF, 8'h00, 4'b0000, 1'b1, 2, 4,
            9'h0A5, 9'h03C, 9'h0FF, 9'h000, 0, 1);
    set_vec(4, 8'h12, 8'h80, 8'h01, 8'h7E, 4'b1000, 1'b1, 0, 4,
            9'h012, 9'h080, 9'h001, 9'h17E, 0, 1);

    lnk.bit_en    = 1'b0;
    lnk.line_in   = 1'b0;
    lnk.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_data",   32'(lnk.out_data),   32'h0);
    chk("rst out_perr",   32'(lnk.out_perr),   32'h0);
    chk("rst out_valid",  32'(lnk.out_valid),  32'h0);
    chk("rst frame_done", 32'(lnk.frame_done), 32'h0);
    chk("rst overrun",    32'(lnk.overrun),    32'h0);
    chk("rst in_frame",   32'(lnk.in_frame),   32'h0);
    rst = 1'b0;

    // Idle line: constant level decodes as all zeros and never matches the sync.
    i0 = inf_cyc; v0 = val_cyc;
    repeat (40) cyc(1'b1, 1'b0);
    line_lvl = 1'b0;
    chk("idle in_frame cycles",  32'(inf_cyc - i0), 32'h0);
    chk("idle out_valid cycles", 32'(val_cyc - v0), 32'h0);

    for (int v = 0; v < 5; v++) begin
      q0 = got_q.size(); f0 = fd_cnt; o0 = ovr_cnt;
      lnk.out_ready = vecs[v].rdy;
      gap = vecs[v].gap;
      send_frame(vecs[v].data, vecs[v].pflip);
      gap = 0;
      drain(3);
      lnk.out_ready = 1'b1;
      drain(3);
      chk($sformatf("v%0d byte count", v), 32'(got_q.size() - q0), 32'(vecs[v].exp_n));
      for (int k = 0; k < vecs[v].exp_n && (q0 + k) < got_q.size(); k++)
        chk($sformatf("v%0d byte%0d {perr,data}", v, k), 32'(got_q[q0 + k]), 32'(vecs[v].exp[k]));
      chk($sformatf("v%0d overrun pulses", v),    32'(ovr_cnt - o0), 32'(vecs[v].exp_ovr));
      chk($sformatf("v%0d frame_done pulses", v), 32'(fd_cnt - f0),  32'(vecs[v].exp_fd));
      chk($sformatf("v%0d in_frame after", v),    32'(lnk.in_frame), 32'h0);
      chk($sformatf("v%0d out_valid after", v),   32'(lnk.out_valid), 32'h0);
      if (vecs[v].rdy)
        chk($sformatf("v%0d frame_done byte", v), 32'(fd_data), 32'(vecs[v].exp[3][7:0]));
    end

    // 0x3F followed by a single 0 already forms 0x7E in the window: lock on that bit.
    send_byte(8'h3F);
    chk("overlap no lock on 0x3F", 32'(lnk.in_frame), 32'h0);
    send_bit(1'b0);
    chk("overlap lock on 0x7E",    32'(lnk.in_frame), 32'h1);
    q0 = got_q.size(); f0 = fd_cnt;
    send_data_byte(8'hA5, 1'b0);
    send_data_byte(8'h3C, 1'b0);
    send_data_byte(8'hFF, 1'b0);
    send_data_byte(8'h00, 1'b0);
    drain(3);
    chk("overlap byte count", 32'(got_q.size() - q0), 32'd4);
    if (got_q.size() - q0 == 4) begin
      chk("overlap byte0", 32'(got_q[q0]),     32'h0A5);
      chk("overlap byte3", 32'(got_q[q0 + 3]), 32'h000);
    end
    chk("overlap frame_done", 32'(fd_cnt - f0), 32'd1);

    // Reset with a held byte and a half-received byte; line left high beforehand.
    lnk.out_ready = 1'b0;
    send_byte(8'h7E);
    send_data_byte(8'hA5, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("pre-reset out_valid", 32'(lnk.out_valid), 32'h1);
    chk("pre-reset in_frame",  32'(lnk.in_frame),  32'h1);
    rst = 1'b1;
    #2;
    chk("mid rst out_valid", 32'(lnk.out_valid), 32'h0);
    chk("mid rst out_data",  32'(lnk.out_data),  32'h0);
    chk("mid rst in_frame",  32'(lnk.in_frame),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    line_lvl = 1'b0;
    lnk.out_ready = 1'b1;
    q0 = got_q.size(); f0 = fd_cnt; o0 = ovr_cnt;
    fr[0] = 8'h5A; fr[1] = 8'hC3; fr[2] = 8'h00; fr[3] = 8'hFF;
    send_frame(fr, 4'b0000);
    drain(3);
    chk("post-rst byte count", 32'(got_q.size() - q0), 32'd4);
    if (got_q.size() - q0 == 4) begin
      chk("post-rst byte0", 32'(got_q[q0]),     32'h05A);
      chk("post-rst byte1", 32'(got_q[q0 + 1]), 32'h0C3);
      chk("post-rst byte2", 32'(got_q[q0 + 2]), 32'h000);
      chk("post-rst byte3", 32'(got_q[q0 + 3]), 32'h0FF);
    end
    chk("post-rst frame_done", 32'(fd_cnt - f0),  32'd1);
    chk("post-rst overrun",    32'(ovr_cnt - o0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
